// File: rtl/blram_pkg.sv
// Shared types and helpers for the dual-port block RAM (blram_dp and its storage core).
package blram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int RD_FIRST  = 0;
    localparam int WR_FIRST  = 1;
    localparam int PAR_MAX_W = 64;

    // Even parity bit; narrower data is zero-extended, which leaves parity unchanged.
    function automatic logic calc_par(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/blram_dp_core.sv
// Raw storage for blram_dp: one write port, two registered read ports with
// selectable same-address behaviour (read-first or write-first).
module blram_dp_core
    import blram_pkg::*;
#(
    parameter int WORD_W  = 10,
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 64,
    parameter int RD_MODE = RD_FIRST
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        re,
    input  logic [ADDR_W-1:0] raddr [2],
    output logic [WORD_W-1:0] rdata [2]
);

    logic [WORD_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic              fwd;
            logic [WORD_W-1:0] q_reg;

            // Write-first forwards the incoming word; read-first sees the array's old contents.
            assign fwd = (RD_MODE == WR_FIRST) && we && (waddr == raddr[gi]);

            always_ff @(posedge clk) begin
                if (srst) begin
                    q_reg <= '0;
                end else if (re[gi]) begin
                    q_reg <= fwd ? wdata : mem_reg[raddr[gi]];
                end
            end

            assign rdata[gi] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/blram_dp.sv
// Dual-port block RAM with req/ready handshake, self-clear FSM and range checks.
// Build option: define RAM_PARITY_EN to store and check an even-parity bit per word.
module blram_dp
    import blram_pkg::*;
#(
    parameter int              DATA_W    = 10,
    parameter int              ADDR_W    = 6,
    parameter int              DEPTH     = 64,
    parameter int              RD_MODE   = RD_FIRST,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    output logic              o_busy,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_wpar_inv,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_perr,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_perr,
    output logic              o_err_oob
);

`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              busy;
    logic              a_acc;
    logic              b_acc;
    logic              a_oob;
    logic              b_oob;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [WORD_W-1:0] wr_word;
    logic [1:0]        rd_en;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [WORD_W-1:0] rd_word [2];
    logic              a_rvalid_reg;
    logic              b_rvalid_reg;
    logic              a_zero_reg;
    logic              b_zero_reg;
    logic              oob_reg;

    assign busy    = (state_reg == ST_CLEAR);
    assign o_busy  = busy;
    assign a_ready = !busy;
    assign b_ready = !busy;
    assign a_acc   = a_req && !busy;
    assign b_acc   = b_req && !busy;
    assign a_oob   = {1'b0, a_addr} >= DEPTH_LIM;
    assign b_oob   = {1'b0, b_addr} >= DEPTH_LIM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ADDR) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_clear) begin
                        state_reg <= ST_CLEAR;
                        cnt_reg   <= '0;
                    end
                end
            endcase
        end
    end

    // The clear sequence owns the write port; port A never competes because it is not ready then.
    assign wr_en   = busy || (a_acc && a_we && !a_oob);
    assign wr_addr = busy ? cnt_reg : a_addr;
    assign wr_data = busy ? CLEAR_VAL : a_wdata;

`ifdef RAM_PARITY_EN
    assign wr_word = {calc_par(PAR_MAX_W'(wr_data)) ^ (!busy && a_wpar_inv), wr_data};
`else
    logic unused_wpar_inv;
    assign unused_wpar_inv = a_wpar_inv;
    assign wr_word         = wr_data;
`endif

    // Out-of-range reads never touch the array; their data is forced to zero at the output.
    assign rd_en[0]   = a_acc && !a_we && !a_oob;
    assign rd_en[1]   = b_acc && !b_oob;
    assign rd_addr[0] = a_addr;
    assign rd_addr[1] = b_addr;

    blram_dp_core #(
        .WORD_W  (WORD_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .RD_MODE (RD_MODE)
    ) u_core (
        .clk   (clk),
        .srst  (rst),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_word),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid_reg <= 1'b0;
            b_rvalid_reg <= 1'b0;
            a_zero_reg   <= 1'b0;
            b_zero_reg   <= 1'b0;
            oob_reg      <= 1'b0;
        end else begin
            a_rvalid_reg <= a_acc && !a_we;
            b_rvalid_reg <= b_acc;
            oob_reg      <= (a_acc && a_oob) || (b_acc && b_oob);
            if (a_acc && !a_we) begin
                a_zero_reg <= a_oob;
            end
            if (b_acc) begin
                b_zero_reg <= b_oob;
            end
        end
    end

    assign a_rvalid  = a_rvalid_reg;
    assign b_rvalid  = b_rvalid_reg;
    assign o_err_oob = oob_reg;
    assign a_rdata   = a_zero_reg ? '0 : rd_word[0][DATA_W-1:0];
    assign b_rdata   = b_zero_reg ? '0 : rd_word[1][DATA_W-1:0];

`ifdef RAM_PARITY_EN
    assign a_perr = a_rvalid_reg && !a_zero_reg &&
                    (calc_par(PAR_MAX_W'(rd_word[0][DATA_W-1:0])) != rd_word[0][DATA_W]);
    assign b_perr = b_rvalid_reg && !b_zero_reg &&
                    (calc_par(PAR_MAX_W'(rd_word[1][DATA_W-1:0])) != rd_word[1][DATA_W]);
`else
    assign a_perr = 1'b0;
    assign b_perr = 1'b0;
`endif

endmodule
